// File: rtl/cpu_run_pkg.sv
// Shared types and parameter-range constants for the CPU run controller.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    RUN      = 3'd2,
    HALTED   = 3'd3,
    TIMEOUT  = 3'd4
  } run_state_e;

  localparam int MIN_RESET_CYCLES = 1;
  localparam int MIN_HALT_REPEAT  = 1;
  localparam int MIN_MAX_CYCLES   = 1;

  // Out-of-range parameters are clamped to the nearest legal value.
  function automatic int clamp_min(input int value, input int min_value);
    return (value < min_value) ? min_value : value;
  endfunction

endpackage

// File: rtl/run_halt_detect.sv
// Watches the core PC during RUN and flags halt once it has stayed put for
// HALT_REPEAT consecutive compares.
module run_halt_detect
  import cpu_run_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            halt
);

  localparam int TARGET = clamp_min(HALT_REPEAT, MIN_HALT_REPEAT);
  localparam int SW     = $clog2(TARGET + 1);

  logic [PC_W-1:0] pc_prev_q, pc_prev_d;
  logic            loaded_q, loaded_d;
  logic [SW-1:0]   stable_q, stable_d;

  always_comb begin
    pc_prev_d = pc_prev_q;
    loaded_d  = loaded_q;
    stable_d  = stable_q;
    halt      = 1'b0;
    if (clear) begin
      loaded_d = 1'b0;
      stable_d = '0;
    end else if (en) begin
      pc_prev_d = pc;
      loaded_d  = 1'b1;
      // The first RUN cycle only captures the PC; compares start after that.
      if (loaded_q) begin
        stable_d = (pc == pc_prev_q) ? stable_q + SW'(1) : '0;
        halt     = (pc == pc_prev_q) && (stable_q == SW'(TARGET - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_prev_q <= '0;
      loaded_q  <= 1'b0;
      stable_q  <= '0;
    end else begin
      pc_prev_q <= pc_prev_d;
      loaded_q  <= loaded_d;
      stable_q  <= stable_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences the core reset pulse, counts RUN cycles and ends
// the run on PC stall (HALTED) or cycle-budget exhaustion (TIMEOUT).
// Handshake: start is a one-cycle request sampled on the rising edge; done is
// sticky until the next start or reset, with timeout qualifying why it ended.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 10000,
  parameter int HALT_REPEAT  = 3,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_dbg
);

  localparam int HOLD_CYCLES = clamp_min(RESET_CYCLES, MIN_RESET_CYCLES);
  localparam int BUDGET      = clamp_min(MAX_CYCLES, MIN_MAX_CYCLES);
  localparam int HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             halt;

  run_halt_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (state_q == RUN),
    .pc    (pc),
    .halt  (halt)
  );

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    cycle_count_d = cycle_count_q;
    cpu_reset_d   = cpu_reset_q;
    running_d     = running_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    // start restarts from any state, including mid-run and mid-hold.
    if (start) begin
      state_d       = RST_HOLD;
      hold_d        = HW'(HOLD_CYCLES - 1);
      cycle_count_d = '0;
      cpu_reset_d   = 1'b1;
      running_d     = 1'b0;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: cpu_reset_d = 1'b1;
        RST_HOLD: begin
          if (hold_q == '0) begin
            state_d     = RUN;
            cpu_reset_d = 1'b0;
            running_d   = 1'b1;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        RUN: begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
          // Halt takes priority over a budget hit on the same edge.
          if (halt) begin
            state_d   = HALTED;
            running_d = 1'b0;
            done_d    = 1'b1;
          end else if (cycle_count_d == CNT_W'(BUDGET)) begin
            state_d   = TIMEOUT;
            running_d = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        HALTED, TIMEOUT: begin
          cpu_reset_d = 1'b0;
          running_d   = 1'b0;
        end
        default: begin
          state_d     = IDLE;
          cpu_reset_d = 1'b1;
          running_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      cycle_count_q <= '0;
      cpu_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cycle_count_q <= cycle_count_d;
      cpu_reset_q   <= cpu_reset_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a table-driven halt run plus hand sequences for
// timeout, halt/budget coincidence, restart and asynchronous reset.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic [35:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [31:0] pc_a, pc_b;
  logic        cpu_reset_a, running_a, done_a, timeout_a;
  logic        cpu_reset_b, running_b, done_b, timeout_b;
  logic [31:0] cycle_count_a, cycle_count_b;
  logic [2:0]  state_dbg_a, state_dbg_b;

  logic [35:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl[13];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RESET_CYCLES(2), .MAX_CYCLES(50), .HALT_REPEAT(3), .PC_W(32), .CNT_W(32)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pc(pc_a),
    .cpu_reset(cpu_reset_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .cycle_count(cycle_count_a), .state_dbg(state_dbg_a)
  );

  cpu_run_ctrl #(
    .RESET_CYCLES(2), .MAX_CYCLES(6), .HALT_REPEAT(3), .PC_W(32), .CNT_W(32)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pc(pc_b),
    .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b),
    .timeout(timeout_b), .cycle_count(cycle_count_b), .state_dbg(state_dbg_b)
  );

  function automatic logic [35:0] pk(logic cr, logic rn, logic dn, logic to,
                                     logic [31:0] c);
    return {cr, rn, dn, to, c};
  endfunction

  function automatic logic [35:0] obs(bit sel);
    if (sel) return {cpu_reset_b, running_b, done_b, timeout_b, cycle_count_b};
    return {cpu_reset_a, running_a, done_a, timeout_a, cycle_count_a};
  endfunction

  task automatic check_pop(input string name, input bit sel);
    logic [35:0] exp;
    logic [35:0] act;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    exp = exp_q.pop_front();
    act = obs(sel);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cr=%0b run=%0b done=%0b to=%0b cnt=%0d, expected cr=%0b run=%0b done=%0b to=%0b cnt=%0d",
               name, act[35], act[34], act[33], act[32], act[31:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, check after the edge.
  task automatic cyc(input string name, input bit sel, input logic st,
                     input logic [31:0] p, input logic [35:0] exp);
    if (sel) begin
      start_b = st; pc_b = p; start_a = 1'b0;
    end else begin
      start_a = st; pc_a = p; start_b = 1'b0;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_pop(name, sel);
  endtask

  task automatic check_now(input string name, input bit sel, input logic [35:0] exp);
    exp_q.push_back(exp);
    check_pop(name, sel);
  endtask

  task automatic chk_state(input string name, input logic [2:0] act,
                           input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: state got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h3000, pk(1, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 32'h3000, pk(1, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 32'h3000, pk(0, 1, 0, 0, 0)};
    tbl[3]  = '{1'b0, 32'h3000, pk(0, 1, 0, 0, 1)};
    tbl[4]  = '{1'b0, 32'h3004, pk(0, 1, 0, 0, 2)};
    tbl[5]  = '{1'b0, 32'h3008, pk(0, 1, 0, 0, 3)};
    tbl[6]  = '{1'b0, 32'h300C, pk(0, 1, 0, 0, 4)};
    tbl[7]  = '{1'b0, 32'h3010, pk(0, 1, 0, 0, 5)};
    tbl[8]  = '{1'b0, 32'h3010, pk(0, 1, 0, 0, 6)};
    tbl[9]  = '{1'b0, 32'h3010, pk(0, 1, 0, 0, 7)};
    tbl[10] = '{1'b0, 32'h3010, pk(0, 0, 1, 0, 8)};
    tbl[11] = '{1'b0, 32'h3010, pk(0, 0, 1, 0, 8)};
    tbl[12] = '{1'b0, 32'h3014, pk(0, 0, 1, 0, 8)};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; pc_a = '0; pc_b = '0;
    #1;
    check_now("reset_state", 1'b0, pk(1, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 4; i++)
      cyc("idle_no_start", 1'b0, 1'b0, 32'($urandom_range(0, 32'hFFFF)), pk(1, 0, 0, 0, 0));

    for (int i = 0; i < 13; i++)
      cyc($sformatf("halt_run[%0d]", i), 1'b0, tbl[i].start, tbl[i].pc, tbl[i].exp);
    chk_state("halt_state", state_dbg_a, 3'(HALTED));

    cyc("to_start", 1'b0, 1'b1, 32'h0, pk(1, 0, 0, 0, 0));
    cyc("to_hold", 1'b0, 1'b0, 32'h0, pk(1, 0, 0, 0, 0));
    cyc("to_enter", 1'b0, 1'b0, 32'h0, pk(0, 1, 0, 0, 0));
    for (int n = 1; n < 50; n++)
      cyc("to_count", 1'b0, 1'b0, 32'(n * 4), pk(0, 1, 0, 0, 32'(n)));
    cyc("to_expire", 1'b0, 1'b0, 32'd200, pk(0, 0, 1, 1, 50));
    cyc("to_frozen", 1'b0, 1'b0, 32'd204, pk(0, 0, 1, 1, 50));
    chk_state("to_state", state_dbg_a, 3'(TIMEOUT));

    cyc("rs_start", 1'b0, 1'b1, 32'h100, pk(1, 0, 0, 0, 0));
    cyc("rs_hold", 1'b0, 1'b0, 32'h100, pk(1, 0, 0, 0, 0));
    cyc("rs_enter", 1'b0, 1'b0, 32'h100, pk(0, 1, 0, 0, 0));
    for (int n = 1; n <= 20; n++)
      cyc("rs_count", 1'b0, 1'b0, 32'h100 + 32'(n * 4), pk(0, 1, 0, 0, 32'(n)));
    cyc("rs_restart_run", 1'b0, 1'b1, 32'h200, pk(1, 0, 0, 0, 0));
    cyc("rs_restart_hold", 1'b0, 1'b1, 32'h200, pk(1, 0, 0, 0, 0));
    cyc("rs_hold2", 1'b0, 1'b0, 32'h200, pk(1, 0, 0, 0, 0));
    cyc("rs_enter2", 1'b0, 1'b0, 32'h200, pk(0, 1, 0, 0, 0));
    for (int n = 1; n <= 3; n++)
      cyc("rs_count2", 1'b0, 1'b0, 32'h200 + 32'(n * 4), pk(0, 1, 0, 0, 32'(n)));

    #2 reset = 1'b1;
    #1;
    check_now("async_run", 1'b0, pk(1, 0, 0, 0, 0));
    chk_state("async_run_state", state_dbg_a, 3'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    cyc("post_reset_idle", 1'b0, 1'b0, 32'h0, pk(1, 0, 0, 0, 0));
    cyc("ah_start", 1'b0, 1'b1, 32'h0, pk(1, 0, 0, 0, 0));
    chk_state("ah_in_hold", state_dbg_a, 3'(RST_HOLD));
    #2 reset = 1'b1;
    #1;
    check_now("async_hold", 1'b0, pk(1, 0, 0, 0, 0));
    chk_state("async_hold_state", state_dbg_a, 3'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    cyc("ah_idle", 1'b0, 1'b0, 32'h0, pk(1, 0, 0, 0, 0));

    cyc("co_start", 1'b1, 1'b1, 32'h10, pk(1, 0, 0, 0, 0));
    cyc("co_hold", 1'b1, 1'b0, 32'h10, pk(1, 0, 0, 0, 0));
    cyc("co_enter", 1'b1, 1'b0, 32'h10, pk(0, 1, 0, 0, 0));
    cyc("co_c1", 1'b1, 1'b0, 32'h10, pk(0, 1, 0, 0, 1));
    cyc("co_c2", 1'b1, 1'b0, 32'h14, pk(0, 1, 0, 0, 2));
    cyc("co_c3", 1'b1, 1'b0, 32'h18, pk(0, 1, 0, 0, 3));
    cyc("co_c4", 1'b1, 1'b0, 32'h18, pk(0, 1, 0, 0, 4));
    cyc("co_c5", 1'b1, 1'b0, 32'h18, pk(0, 1, 0, 0, 5));
    cyc("co_both", 1'b1, 1'b0, 32'h18, pk(0, 0, 1, 0, 6));
    cyc("co_frozen", 1'b1, 1'b0, 32'h18, pk(0, 0, 1, 0, 6));
    chk_state("co_state", state_dbg_b, 3'(HALTED));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
